// File: rtl/bp_mc_mmio_link_bridge.sv
// bp_mc_mmio_link_bridge
// Bridges a single-outstanding MMIO command port onto a packetised network link.
// Outbound: REQ_FIFO writes assemble a request packet, which is sent once a credit is
// available. Inbound: response packets queue in a FIFO and are read back word by word.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   cmd_v_i/cmd_ready_o       MMIO command handshake (cmd_we_i, cmd_addr_i, cmd_data_i)
//   resp_v_o/resp_yumi_i      MMIO response handshake (resp_data_o)
//   req_pkt_o/req_v_o/req_ready_i   network request packet out
//   rsp_pkt_i/rsp_v_i/rsp_ready_o   network response packet in
//   credit_return_i           one request credit returned per asserted cycle
module bp_mc_mmio_link_bridge #(
   parameter int unsigned word_width_p   = 64,
   parameter int unsigned pkt_words_p    = 2,
   parameter int unsigned rsp_fifo_els_p = 8,
   parameter int unsigned max_credits_p  = 16
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic                                cmd_v_i,
   output logic                                cmd_ready_o,
   input  logic                                cmd_we_i,
   input  logic [15:0]                         cmd_addr_i,
   input  logic [word_width_p-1:0]             cmd_data_i,
   output logic                                resp_v_o,
   output logic [word_width_p-1:0]             resp_data_o,
   input  logic                                resp_yumi_i,
   output logic [pkt_words_p*word_width_p-1:0] req_pkt_o,
   output logic                                req_v_o,
   input  logic                                req_ready_i,
   input  logic [pkt_words_p*word_width_p-1:0] rsp_pkt_i,
   input  logic                                rsp_v_i,
   output logic                                rsp_ready_o,
   input  logic                                credit_return_i
);

   localparam int unsigned cred_w_lp = $clog2(max_credits_p + 1);
   localparam int unsigned idx_w_lp  = (pkt_words_p > 1) ? $clog2(pkt_words_p) : 1;
   localparam int unsigned ptr_w_lp  = $clog2(rsp_fifo_els_p);
   localparam int unsigned cnt_w_lp  = $clog2(rsp_fifo_els_p + 1);

   localparam logic [idx_w_lp-1:0]  last_idx_lp = idx_w_lp'(pkt_words_p - 1);
   localparam logic [cred_w_lp-1:0] max_cred_lp = cred_w_lp'(max_credits_p);
   localparam logic [cnt_w_lp-1:0]  fifo_els_lp = cnt_w_lp'(rsp_fifo_els_p);

   typedef enum logic [0:0] {StIdle, StResp} state_e;

   state_e                                     state_q;
   logic [word_width_p-1:0]                    resp_data_q, resp_data_d;
   logic [pkt_words_p-1:0][word_width_p-1:0]   pkt_q;
   logic [idx_w_lp-1:0]                        wr_idx_q, rd_idx_q;
   logic                                       pkt_full_q;
   logic [cred_w_lp-1:0]                       credits_q;
   logic [2:0]                                 status_q, status_set, status_clr;
   logic [pkt_words_p-1:0][word_width_p-1:0]   mem [rsp_fifo_els_p];
   logic [ptr_w_lp-1:0]                        wr_ptr_q, rd_ptr_q;
   logic [cnt_w_lp-1:0]                        cnt_q;

   logic cmd_fire, hit_req, hit_cred, hit_rsp, hit_ent, hit_stat;
   logic rsp_empty, rsp_full, pop_word, pop_pkt, push, send;
   logic [word_width_p-1:0] entries;

   assign hit_req  = (cmd_addr_i == 16'h1000);
   assign hit_cred = (cmd_addr_i == 16'h2000);
   assign hit_rsp  = (cmd_addr_i == 16'h3000);
   assign hit_ent  = (cmd_addr_i == 16'h4000);
   assign hit_stat = (cmd_addr_i == 16'h5000);

   assign cmd_ready_o = reset_n_i & (state_q == StIdle) & ~pkt_full_q;
   assign cmd_fire    = cmd_v_i & cmd_ready_o;

   assign rsp_empty = (cnt_q == '0);
   assign rsp_full  = (cnt_q == fifo_els_lp);
   assign pop_word  = cmd_fire & ~cmd_we_i & hit_rsp & ~rsp_empty;
   assign pop_pkt   = pop_word & (rd_idx_q == last_idx_lp);
   // A head packet retiring this cycle frees its slot, so a full FIFO can still take one.
   assign rsp_ready_o = reset_n_i & (~rsp_full | pop_pkt);
   assign push        = rsp_v_i & rsp_ready_o;

   assign req_v_o   = pkt_full_q & (credits_q != '0);
   assign send      = req_v_o & req_ready_i;
   assign req_pkt_o = pkt_q;

   assign resp_v_o    = (state_q == StResp);
   assign resp_data_o = resp_data_q;

   assign entries = word_width_p'(cnt_q) * word_width_p'(pkt_words_p)
                    - word_width_p'(rd_idx_q);

   always_comb begin
      resp_data_d = '0;
      status_set  = '0;
      status_clr  = '0;
      if (cmd_fire) begin
         if (hit_req) begin
            resp_data_d = '0;
         end else if (hit_cred) begin
            if (!cmd_we_i) resp_data_d = word_width_p'(credits_q);
         end else if (hit_rsp) begin
            if (!cmd_we_i) begin
               if (rsp_empty) status_set[0] = 1'b1;
               else           resp_data_d   = mem[rd_ptr_q][rd_idx_q];
            end
         end else if (hit_ent) begin
            if (!cmd_we_i) resp_data_d = entries;
         end else if (hit_stat) begin
            if (!cmd_we_i) resp_data_d = word_width_p'(status_q);
            else           status_clr  = cmd_data_i[2:0];
         end else begin
            status_set[2] = 1'b1;
         end
      end
      if (credit_return_i && !send && credits_q == max_cred_lp) status_set[1] = 1'b1;
   end

   // Packet storage carries no reset; only pointers and counts define FIFO contents.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= rsp_pkt_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= StIdle;
         resp_data_q <= '0;
         pkt_q       <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         pkt_full_q  <= 1'b0;
         credits_q   <= max_cred_lp;
         status_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle:  if (cmd_fire) state_q <= StResp;
            StResp:  if (resp_yumi_i) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase

         if (cmd_fire) resp_data_q <= resp_data_d;

         if (cmd_fire && cmd_we_i && hit_req) begin
            pkt_q[wr_idx_q] <= cmd_data_i;
            if (wr_idx_q == last_idx_lp) begin
               wr_idx_q   <= '0;
               pkt_full_q <= 1'b1;
            end else begin
               wr_idx_q <= wr_idx_q + 1'b1;
            end
         end else if (send) begin
            pkt_full_q <= 1'b0;
         end

         if (send && !credit_return_i) begin
            credits_q <= credits_q - 1'b1;
         end else if (!send && credit_return_i && credits_q != max_cred_lp) begin
            credits_q <= credits_q + 1'b1;
         end

         // Set wins over a same-cycle clear.
         status_q <= (status_q & ~status_clr) | status_set;

         if (pop_word) rd_idx_q <= pop_pkt ? '0 : rd_idx_q + 1'b1;
         if (pop_pkt)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
         if (push && !pop_pkt)      cnt_q <= cnt_q + 1'b1;
         else if (!push && pop_pkt) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_bp_mc_mmio_link_bridge.sv
module tb_bp_mc_mmio_link_bridge;

   localparam logic [15:0] A_REQ  = 16'h1000;
   localparam logic [15:0] A_CRED = 16'h2000;
   localparam logic [15:0] A_RSP  = 16'h3000;
   localparam logic [15:0] A_ENT  = 16'h4000;
   localparam logic [15:0] A_STAT = 16'h5000;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_v_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
   logic [15:0]   cmd_addr_i = '0;
   logic [63:0]   cmd_data_i = '0;
   logic          resp_v_o, resp_yumi_i = 1'b0;
   logic [63:0]   resp_data_o;
   logic [127:0]  req_pkt_o;
   logic          req_v_o, req_ready_i = 1'b0;
   logic [127:0]  rsp_pkt_i = '0;
   logic          rsp_v_i = 1'b0, rsp_ready_o, credit_return_i = 1'b0;

   int            total = 0;
   int            bad = 0;
   logic [63:0]   rd_data, dummy;
   logic          acc_req_v, post_req_v;
   logic [127:0]  acc_req_pkt;
   bit            concurrent_rsp = 1'b0;

   always #5 clk = ~clk;

   bp_mc_mmio_link_bridge dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
      .cmd_v_i         (cmd_v_i),
      .cmd_ready_o     (cmd_ready_o),
      .cmd_we_i        (cmd_we_i),
      .cmd_addr_i      (cmd_addr_i),
      .cmd_data_i      (cmd_data_i),
      .resp_v_o        (resp_v_o),
      .resp_data_o     (resp_data_o),
      .resp_yumi_i     (resp_yumi_i),
      .req_pkt_o       (req_pkt_o),
      .req_v_o         (req_v_o),
      .req_ready_i     (req_ready_i),
      .rsp_pkt_i       (rsp_pkt_i),
      .rsp_v_i         (rsp_v_i),
      .rsp_ready_o     (rsp_ready_o),
      .credit_return_i (credit_return_i)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_cmd(input logic we, input logic [15:0] addr, input logic [63:0] data,
                         output logic [63:0] rdata);
      int n;
      rdata = '0;
      @(negedge clk);
      n = 0;
      while (!cmd_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready_o) begin
         check("cmd_ready_timeout", cmd_ready_o, 1);
         return;
      end
      cmd_v_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_data_i = data;
      if (concurrent_rsp) rsp_v_i = 1'b1;
      @(posedge clk); #1;
      cmd_v_i = 1'b0; rsp_v_i = 1'b0;
      acc_req_v = req_v_o; acc_req_pkt = req_pkt_o;
      n = 0;
      while (!resp_v_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!resp_v_o) begin
         check("resp_timeout", resp_v_o, 1);
         return;
      end
      rdata = resp_data_o;
      resp_yumi_i = 1'b1;
      @(posedge clk); #1;
      resp_yumi_i = 1'b0;
      post_req_v = req_v_o;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [63:0] data);
      do_cmd(1'b1, addr, data, dummy);
   endtask

   task automatic rd(input logic [15:0] addr);
      do_cmd(1'b0, addr, 64'h0, rd_data);
   endtask

   task automatic enq(input logic [63:0] w1, input logic [63:0] w0);
      @(negedge clk);
      rsp_pkt_i = {w1, w0};
      rsp_v_i = 1'b1;
      @(posedge clk); #1;
      rsp_v_i = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_cmd_ready", cmd_ready_o, 0);
      check("rst_resp_v", resp_v_o, 0);
      check("rst_resp_data", resp_data_o, 0);
      check("rst_req_v", req_v_o, 0);
      check("rst_rsp_ready", rsp_ready_o, 0);
      @(negedge clk); reset_n = 1'b1;
      rd(A_CRED); check("rst_credits", rd_data, 16);
      rd(A_ENT);  check("rst_entries", rd_data, 0);
      rd(A_STAT); check("rst_status", rd_data, 0);

      // Two-word request packet
      req_ready_i = 1'b1;
      wr(A_REQ, 64'hA);
      wr(A_REQ, 64'hB);
      check("pkt_v", acc_req_v, 1);
      check("pkt_data", acc_req_pkt, {64'hB, 64'hA});
      check("pkt_v_one_cycle", post_req_v, 0);
      rd(A_CRED); check("credits_15", rd_data, 15);

      // Exhaust credits, then a stalled 17th packet
      for (int p = 0; p < 15; p++) begin
         wr(A_REQ, 64'(p));
         wr(A_REQ, 64'(p + 100));
      end
      rd(A_CRED); check("credits_0", rd_data, 0);
      wr(A_REQ, 64'h11);
      wr(A_REQ, 64'h22);
      check("stall_req_v", req_v_o, 0);
      check("stall_cmd_ready", cmd_ready_o, 0);
      @(negedge clk); credit_return_i = 1'b1;
      @(posedge clk); #1; credit_return_i = 1'b0;
      check("ret_req_v", req_v_o, 1);
      check("ret_pkt", req_pkt_o, {64'h22, 64'h11});
      @(posedge clk); #1;
      check("sent_req_v", req_v_o, 0);
      check("sent_cmd_ready", cmd_ready_o, 1);
      rd(A_CRED); check("credits_after_ret", rd_data, 0);

      // Refill credits, then overflow one
      @(negedge clk); credit_return_i = 1'b1;
      repeat (16) @(posedge clk);
      #1; credit_return_i = 1'b0;
      rd(A_CRED); check("credits_refill", rd_data, 16);
      rd(A_STAT); check("status_no_ovf", rd_data, 0);
      @(negedge clk); credit_return_i = 1'b1;
      @(posedge clk); #1; credit_return_i = 1'b0;
      rd(A_CRED); check("credits_capped", rd_data, 16);
      rd(A_STAT); check("status_ovf", rd_data, 2);
      wr(A_STAT, 64'h2);
      rd(A_STAT); check("status_ovf_clr", rd_data, 0);

      // Unmapped and read-only accesses
      rd(16'h6000); check("unmapped_data", rd_data, 0);
      rd(A_STAT);   check("status_unmapped", rd_data, 4);
      do_cmd(1'b1, A_CRED, 64'h5, rd_data); check("ro_write_data", rd_data, 0);
      rd(A_CRED);   check("ro_write_noeffect", rd_data, 16);
      rd(A_REQ);    check("req_fifo_read", rd_data, 0);
      wr(A_STAT, 64'h4);
      rd(A_STAT);   check("status_unmapped_clr", rd_data, 0);

      // Two response packets read back word 0 first
      enq(64'd1, 64'd2);
      enq(64'd3, 64'd4);
      rd(A_ENT); check("entries_4", rd_data, 4);
      rd(A_RSP); check("rsp_w0", rd_data, 2);
      rd(A_ENT); check("entries_3", rd_data, 3);
      rd(A_RSP); check("rsp_w1", rd_data, 1);
      rd(A_RSP); check("rsp_w2", rd_data, 4);
      rd(A_RSP); check("rsp_w3", rd_data, 3);
      rd(A_ENT); check("entries_0", rd_data, 0);

      // Empty read
      rd(A_RSP);  check("empty_data", rd_data, 0);
      rd(A_STAT); check("status_empty", rd_data, 1);
      wr(A_STAT, 64'h1);
      rd(A_STAT); check("status_empty_clr", rd_data, 0);

      // Fill the FIFO, then retire a packet while a new one arrives
      for (int k = 0; k < 8; k++) enq(64'h101 + 64'(2 * k), 64'h100 + 64'(2 * k));
      @(negedge clk);
      check("full_rsp_ready", rsp_ready_o, 0);
      rd(A_ENT); check("entries_16", rd_data, 16);
      rd(A_RSP); check("full_w0", rd_data, 64'h100);
      rsp_pkt_i = {64'h201, 64'h200};
      concurrent_rsp = 1'b1;
      rd(A_RSP); check("full_w1", rd_data, 64'h101);
      concurrent_rsp = 1'b0;
      rd(A_ENT); check("entries_still_16", rd_data, 16);
      @(negedge clk);
      check("still_full", rsp_ready_o, 0);
      for (int k = 1; k < 8; k++) begin
         rd(A_RSP); check("drain_even", rd_data, 64'h100 + 64'(2 * k));
         rd(A_RSP); check("drain_odd", rd_data, 64'h101 + 64'(2 * k));
      end
      rd(A_RSP); check("drain_new_w0", rd_data, 64'h200);
      rd(A_RSP); check("drain_new_w1", rd_data, 64'h201);
      rd(A_ENT); check("drain_entries_0", rd_data, 0);

      // Reset during a pending response with a partial packet
      wr(A_REQ, 64'h1);
      wr(A_REQ, 64'h2);
      rd(A_CRED); check("pre_reset_credits", rd_data, 15);
      req_ready_i = 1'b0;
      @(negedge clk);
      cmd_v_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = A_REQ; cmd_data_i = 64'h55;
      @(posedge clk); #1;
      cmd_v_i = 1'b0;
      check("mid_resp_v", resp_v_o, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_resp_v", resp_v_o, 0);
      check("mid_rst_resp_data", resp_data_o, 0);
      check("mid_rst_cmd_ready", cmd_ready_o, 0);
      check("mid_rst_rsp_ready", rsp_ready_o, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      rd(A_CRED); check("post_rst_credits", rd_data, 16);
      wr(A_REQ, 64'h77);
      wr(A_REQ, 64'h88);
      check("post_rst_req_v", acc_req_v, 1);
      check("post_rst_pkt", acc_req_pkt, {64'h88, 64'h77});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
